// File: rtl/nth_bit_set_from_lsb.sv
// nth_bit_set_from_lsb
// Finds the n-th set bit (1-based, counted from the LSB) of a captured
// vector by peeling off the lowest set bit once per cycle. The result is
// reported as a one-hot mask, a binary index and a found flag.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both 1. The request side presents
// ready_o only in IDLE. The result side holds valid_o and all result
// fields stable in DONE until the edge where ready_i is also 1.
// Requests offered while the block is busy are simply not accepted.
module nth_bit_set_from_lsb #(
  parameter  int WIDTH = 12,
  localparam int NW    = $clog2(WIDTH + 1),
  localparam int IW    = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] vec_i,
  input  logic [NW-1:0]    n_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IW-1:0]    index_o,
  output logic             found_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Sequential state.
  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [NW-1:0]    cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] onehot_q;
  logic [IW-1:0]    index_q;
  logic             found_q;

  // Combinational helpers derived only from registered state, so no
  // path exists from vec_i or n_i to any output.
  logic [WIDTH-1:0] lsb_d;
  logic [IW-1:0]    lsb_idx_d;
  logic             scan_empty_d;
  logic             scan_hit_d;

  // Binary position of a one-hot (or zero) vector; zero maps to index 0.
  function automatic logic [IW-1:0] pos_of(input logic [WIDTH-1:0] oh);
    logic [IW-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) begin
        p = p | IW'(i);
      end
    end
    return p;
  endfunction

  // Isolate the lowest set bit of the working vector and classify the
  // current scan step.
  always_comb begin
    lsb_d        = work_q & (~work_q + WIDTH'(1));
    lsb_idx_d    = pos_of(lsb_d);
    scan_empty_d = (cnt_q == '0) || (work_q == '0);
    scan_hit_d   = (cnt_q == NW'(1));
  end

  // Single FSM: capture in IDLE, peel one set bit per SCAN cycle, hold
  // the registered result in DONE until the consumer takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      index_q  <= '0;
      found_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            // ready_q is always 1 in IDLE, so valid_i alone is the handshake.
            work_q   <= vec_i;
            cnt_q    <= n_i;
            ready_q  <= 1'b0;
            onehot_q <= '0;
            index_q  <= '0;
            found_q  <= 1'b0;
            state_q  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_empty_d) begin
            // Rank zero, or the vector ran out of set bits first: an
            // oversized rank therefore never wraps around.
            onehot_q <= '0;
            index_q  <= '0;
            found_q  <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end else if (scan_hit_d) begin
            onehot_q <= lsb_d;
            index_q  <= lsb_idx_d;
            found_q  <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            work_q <= work_q ^ lsb_d;
            cnt_q  <= cnt_q - NW'(1);
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign onehot_o = onehot_q;
  assign index_o  = index_q;
  assign found_o  = found_q;

  // Result mask is never more than one-hot.
  a_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(onehot_q));

  // A found result carries a mask that matches its index.
  a_index_consistent : assert property (@(posedge clk_i) disable iff (rst_i)
    found_q |-> (onehot_q == (WIDTH'(1) << index_q)));

  // A not-found result carries all-zero fields.
  a_not_found_zero : assert property (@(posedge clk_i) disable iff (rst_i)
    !found_q |-> ((onehot_q == '0) && (index_q == '0)));

  // The two sides of the block are never open at the same time.
  a_ready_valid_excl : assert property (@(posedge clk_i) disable iff (rst_i)
    !(ready_q && valid_q));

  // A pending result stays put until it is taken.
  a_result_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_q && !ready_i) |=> (valid_q && $stable(onehot_q) &&
                               $stable(index_q) && $stable(found_q)));

  // ready/valid flags track the FSM state.
  a_flags_match_state : assert property (@(posedge clk_i) disable iff (rst_i)
    (ready_q == (state_q == ST_IDLE)) && (valid_q == (state_q == ST_DONE)));

endmodule

// File: doc/nth_bit_set_from_lsb.md
NTH_BIT_SET_FROM_LSB -- requirements
Module: nth_bit_set_from_lsb

Interface
REQ-001 SHALL have parameter WIDTH, default 12: input vector width, legal range 2..64.
REQ-002 SHALL have derived parameter NW = $clog2(WIDTH+1): width of the rank input.
REQ-003 SHALL have derived parameter IW = max(1, $clog2(WIDTH)): width of the index output.
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-005 SHALL have clk_i, input, 1 bit: rising-edge clock.
REQ-006 SHALL have rst_i, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have valid_i, input, 1 bit: request valid.
REQ-008 SHALL have ready_o, output, 1 bit: block can accept a request.
REQ-009 SHALL have vec_i, input, WIDTH bits: vector to search.
REQ-010 SHALL have n_i, input, NW bits: 1-based rank of the set bit sought, counted from the LSB.
REQ-011 SHALL have valid_o, output, 1 bit: result valid.
REQ-012 SHALL have ready_i, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have onehot_o, output, WIDTH bits: one-hot mask of the n-th set bit.
REQ-014 SHALL have index_o, output, IW bits: binary position of that bit.
REQ-015 SHALL have found_o, output, 1 bit: n-th set bit exists.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, SCAN, DONE.
REQ-017 SHALL drive ready_o = 1 only in IDLE and valid_o = 1 only in DONE.
REQ-018 SHALL accept a request on a rising edge with valid_i && ready_o, then register vec_i into work, n_i into cnt, and enter SCAN.
REQ-019 SHALL compute lsb = work & (~work + 1) each SCAN cycle.
REQ-020 SHALL apply these SCAN decisions, in priority order, on each edge:
- cnt == 0 or work == 0: enter DONE with found_o = 0, onehot_o = 0, index_o = 0.
- cnt == 1: enter DONE with found_o = 1, onehot_o = lsb, index_o = position of lsb.
- otherwise: work <= work ^ lsb, cnt <= cnt - 1, stay in SCAN.
REQ-021 SHALL give a latency from the accepting edge to the edge that raises valid_o of:
- n edges when the request is found;
- popcount(vec_i) + 1 edges when n_i > popcount;
- 1 edge when n_i == 0 or vec_i == 0.
REQ-022 SHALL hold onehot_o, index_o and found_o stable in DONE until valid_o && ready_i.
REQ-023 SHALL return to IDLE on the edge with valid_o && ready_i, so ready_o = 1 in the following cycle.
REQ-024 SHALL ignore valid_i, vec_i and n_i while in SCAN or DONE; requests are never queued.
REQ-025 SHALL treat an n_i value above WIDTH as not found, with no wrap-around.
REQ-026 SHALL keep onehot_o either zero or exactly one-hot, and keep index_o consistent with onehot_o.
REQ-027 SHALL make the outputs registered, with no combinational path from vec_i or n_i to any output.

Reset
REQ-028 SHALL, while rst_i = 1, asynchronously force: state = IDLE, work = 0, cnt = 0, valid_o = 0, onehot_o = 0, index_o = 0, found_o = 0, ready_o = 1.
REQ-029 SHALL ignore any handshake during a cycle in which rst_i = 1.
REQ-030 SHALL, on reset asserted mid-SCAN or mid-DONE, discard the pending result; no valid_o pulse follows the release.

Verification (WIDTH = 12)
REQ-031 SHALL cover: vec_i = 0x2CD, n_i = 2 -> onehot_o = 0x004, index_o = 2, found_o = 1, valid_o 2 edges after accept.
REQ-032 SHALL cover: vec_i = 0x00F, n_i = 4 -> onehot_o = 0x008, index_o = 3, found_o = 1, latency 4.
REQ-033 SHALL cover: vec_i = 0x008, n_i = 2 -> found_o = 0, onehot_o = 0, index_o = 0, latency 2.
REQ-034 SHALL cover: vec_i = 0x000, n_i = 1 -> found_o = 0, latency 1; and vec_i = 0xFFF, n_i = 0 -> found_o = 0, latency 1.
REQ-035 SHALL cover: vec_i = 0xC01, n_i = 3 with ready_i held low 3 cycles -> onehot_o = 0x800, index_o = 11, outputs stable throughout, a second valid_i pulse ignored, ready_o = 1 the cycle after ready_i rises.
REQ-036 SHALL cover: vec_i = 0xFFF, n_i = 12 with rst_i pulsed at cycle 5 -> all outputs 0 and ready_o = 1 immediately, no valid_o afterwards, next request processed normally.
